// File: rtl/cmd_cfg.sv
// Command-configuration stage: applies host setpoint commands, sequences motor spin-up and
// inertial calibration, and acknowledges each command through the UART response path.
module cmd_cfg #(
  parameter int unsigned FAST_SIM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  output logic               clr_cmd_rdy,
  output logic [7:0]         resp,
  output logic               send_resp,
  input  logic               cal_done,
  output logic               strt_cal,
  output logic               inertial_cal,
  output logic               motors_off,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst
);

  localparam int unsigned TimerW = (FAST_SIM != 0) ? 9 : 26;

  localparam logic [7:0] OpPtch  = 8'h02;
  localparam logic [7:0] OpRoll  = 8'h03;
  localparam logic [7:0] OpYaw   = 8'h04;
  localparam logic [7:0] OpThrst = 8'h05;
  localparam logic [7:0] OpCal   = 8'h06;
  localparam logic [7:0] OpEmgl  = 8'h07;
  localparam logic [7:0] OpMoff  = 8'h08;

  localparam logic [7:0] RespAck = 8'hA5;
  localparam logic [7:0] RespErr = 8'hEE;

  typedef enum logic [1:0] {StIdle, StSpin, StCal} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic signed [15:0]  d_ptch_q, d_roll_q, d_yaw_q;
  logic [8:0]          thrst_q;
  logic                motors_off_q;
  logic                inertial_cal_q;

  logic accept;
  logic known;
  logic cal_ack;
  logic timer_full;

  always_comb begin
    known = 1'b0;
    case (cmd)
      OpPtch, OpRoll, OpYaw, OpThrst, OpCal, OpEmgl, OpMoff: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // Commands are only consumed in IDLE; anything presented during spin-up/calibration waits.
  assign accept     = (state_q == StIdle) && cmd_rdy;
  assign timer_full = &timer_q;
  assign cal_ack    = (state_q == StCal) && cal_done;

  // Handshake pulses belong to the cycle the command (or cal_done) is seen.
  always_comb begin
    clr_cmd_rdy = accept;
    send_resp   = (accept && (cmd != OpCal)) || cal_ack;
    resp        = (accept && !known) ? RespErr : RespAck;
    strt_cal    = (state_q == StSpin) && timer_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      d_ptch_q       <= '0;
      d_roll_q       <= '0;
      d_yaw_q        <= '0;
      thrst_q        <= '0;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_rdy) begin
            case (cmd)
              OpPtch:  d_ptch_q <= data;
              OpRoll:  d_roll_q <= data;
              OpYaw:   d_yaw_q  <= data;
              OpThrst: thrst_q  <= data[8:0];
              OpCal: begin
                motors_off_q   <= 1'b0;
                inertial_cal_q <= 1'b1;
                timer_q        <= '0;
                state_q        <= StSpin;
              end
              OpEmgl: begin
                d_ptch_q <= '0;
                d_roll_q <= '0;
                d_yaw_q  <= '0;
                thrst_q  <= '0;
              end
              OpMoff:  motors_off_q <= 1'b1;
              default: ;
            endcase
          end
        end
        StSpin: begin
          // Hold at all-ones on exit so the timer never wraps.
          if (timer_full) begin
            state_q <= StCal;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StCal: begin
          if (cal_done) begin
            state_q        <= StIdle;
            inertial_cal_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign motors_off   = motors_off_q;
  assign inertial_cal = inertial_cal_q;

endmodule

// File: doc/cmd_cfg.md
# cmd_cfg

Command-configuration stage of the QuadCopter, directly downstream of the UART command receiver. It consumes each validated host command (8-bit opcode plus 16-bit payload) and updates the desired pitch/roll/yaw/thrust registers that feed the flight controller. It also sequences motor spin-up and inertial calibration, and returns a one-byte acknowledge to the host through the UART response path.

## Interface
- FAST_SIM, default 1: 1 selects a 9-bit spin-up timer (512 cycles); 0 selects a 26-bit timer (2^26 cycles, about 1.34 s at 50 MHz).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_rdy  in  1  a complete command is available on cmd/data.
- cmd  in  8  opcode.
- data  in  16  payload.
- clr_cmd_rdy  out  1  one-cycle pulse that consumes the command.
- resp  out  8  response byte; 8'hA5 = ack, 8'hEE = unknown opcode.
- send_resp  out  1  one-cycle pulse that starts transmission of resp.
- cal_done  in  1  inertial interface has finished calibration.
- strt_cal  out  1  one-cycle pulse that starts inertial calibration.
- inertial_cal  out  1  high during spin-up and calibration; the flight controller runs motors at calibration speed while it is high.
- motors_off  out  1  forces all ESC outputs to minimum.
- d_ptch, d_roll, d_yaw  out  16  signed desired angles.
- thrst  out  9  unsigned desired thrust.

## Operation
- Opcodes:
  - 02 SET_PTCH: d_ptch <= data.
  - 03 SET_ROLL: d_roll <= data.
  - 04 SET_YAW: d_yaw <= data.
  - 05 SET_THRST: thrst <= data[8:0]; data[15:9] is ignored.
  - 06 SET_CAL: runs the calibration sequence; data is ignored.
  - 07 SET_EMGL: d_ptch, d_roll, d_yaw and thrst all <= 0.
  - 08 SET_MOFF: motors_off <= 1; no other register changes.
  - Any other opcode: no register change; resp = 8'hEE.
- States: IDLE, SPIN, CAL.
- IDLE, cmd_rdy=0: outputs hold.
- IDLE, cmd_rdy=1 with a non-CAL opcode, all in one cycle:
  - clr_cmd_rdy=1.
  - The target register loads on the next edge.
  - send_resp=1, with resp=A5, or EE for an unknown opcode.
  - Remains in IDLE.
- IDLE, cmd_rdy=1 with SET_CAL: clr_cmd_rdy=1; motors_off <= 0; timer <= 0; go to SPIN. No response is sent yet.
- SPIN: inertial_cal=1; timer increments every cycle. When timer is all ones, strt_cal=1 for that cycle and the next state is CAL.
- CAL: inertial_cal=1.
  - On cal_done=1: send_resp=1, resp=A5, next state IDLE. inertial_cal is low from the next cycle.
  - cal_done high in the same cycle as strt_cal is ignored. It is only sampled in CAL.
- SET_CAL is the only command that clears motors_off.
- cmd_rdy asserted during SPIN or CAL is not consumed. clr_cmd_rdy stays 0, and the command is processed on the first IDLE cycle.

## Timing
- Reset values: d_ptch=d_roll=d_yaw=0, thrst=0, motors_off=1, inertial_cal=0, strt_cal=0, send_resp=0, clr_cmd_rdy=0, resp=A5, state=IDLE, timer=0.
- The register update is visible one cycle after the cmd_rdy cycle. clr_cmd_rdy and send_resp are high only in that cmd_rdy cycle.
- Spin-up: strt_cal is high exactly 2^W cycles after the SET_CAL acceptance edge, where W = 9 (FAST_SIM=1) or 26.
- The calibration ack is one cycle wide, in the cycle cal_done is seen high in CAL.
- Back-to-back commands: a new cmd_rdy in the cycle right after an accept is processed normally.
- Reset asserted mid-SPIN or mid-CAL returns all outputs to reset values immediately, including motors_off=1. No ack is sent.
- Payloads are stored unmodified; sign is preserved; there is no saturation.
- Timer wrap cannot occur, because SPIN exits at all-ones.

## Test plan
- After reset, all outputs equal their reset values. SET_PTCH 16'h0100 → clr_cmd_rdy and send_resp pulse in the same single cycle, resp=A5, d_ptch=16'h0100 on the next cycle; all other outputs unchanged.
- SET_ROLL FF80, SET_YAW 0080, SET_THRST 16'hFEFF → d_roll=FF80, d_yaw=0080, thrst=9'h0FF. Each command produces exactly one A5 ack.
- SET_CAL with FAST_SIM=1:
  - motors_off drops 1 cycle after accept; inertial_cal is high for the whole sequence.
  - strt_cal pulses exactly 512 cycles after accept.
  - cal_done driven 20 cycles later → single A5 ack; inertial_cal low on the next cycle.
  - A SET_PTCH presented during CAL is held and processed only after the ack.
- From nonzero setpoints, SET_EMGL → ptch/roll/yaw/thrst all 0, ack A5. Then SET_MOFF → motors_off=1, ack A5. Then SET_CAL → motors_off=0.
- Opcode 8'h01 → resp=EE with one send_resp pulse; no register changes.
- Reset pulsed 100 cycles into SPIN → all reset values; strt_cal never pulses; no ack.
